// File: rtl/axis_iter_divider.sv
// axis_iter_divider: multi-cycle radix-2 restoring divider, responder end of
// the divisor/dividend/dout stream handshake.
//   clk, resetn                 clock, async active-low reset
//   s_axis_divisor_*            divisor channel  (tdata/tvalid/tready)
//   s_axis_dividend_*           dividend channel (tdata/tvalid/tready)
//   m_axis_dout_tdata           {quotient, remainder}
//   m_axis_dout_tvalid          single-cycle result pulse, no back-pressure
module axis_iter_divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t               state_q;
  logic                 dvs_got_q, dnd_got_q;
  logic [WIDTH-1:0]     dvs_raw_q, dnd_raw_q;
  logic [WIDTH-1:0]     dvs_mag_q, quo_q, rem_q;
  logic [CW-1:0]        cnt_q;
  logic                 qneg_q, rneg_q, dz_q;
  logic [2*WIDTH-1:0]   dout_q;
  logic                 valid_q;

  logic                 dvs_hs, dnd_hs;
  logic                 dvs_neg, dnd_neg;
  logic [WIDTH:0]       shifted, trial;

  assign s_axis_divisor_tready  = (state_q == S_IDLE) && !dvs_got_q;
  assign s_axis_dividend_tready = (state_q == S_IDLE) && !dnd_got_q;
  assign dvs_hs = s_axis_divisor_tvalid  && s_axis_divisor_tready;
  assign dnd_hs = s_axis_dividend_tvalid && s_axis_dividend_tready;

  assign dvs_neg = SIGNED && dvs_raw_q[WIDTH-1];
  assign dnd_neg = SIGNED && dnd_raw_q[WIDTH-1];

  // {partial remainder, next dividend bit}; a negative trial shows up in bit WIDTH
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_mag_q};

  assign m_axis_dout_tdata  = dout_q;
  assign m_axis_dout_tvalid = valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      dvs_got_q <= 1'b0;
      dnd_got_q <= 1'b0;
      dvs_raw_q <= '0;
      dnd_raw_q <= '0;
      dvs_mag_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dvs_hs) begin
            dvs_raw_q <= s_axis_divisor_tdata;
            dvs_got_q <= 1'b1;
          end
          if (dnd_hs) begin
            dnd_raw_q <= s_axis_dividend_tdata;
            dnd_got_q <= 1'b1;
          end
          if ((dvs_got_q || dvs_hs) && (dnd_got_q || dnd_hs))
            state_q <= S_PREP;
        end
        S_PREP: begin
          qneg_q    <= dnd_neg ^ dvs_neg;
          rneg_q    <= dnd_neg;
          dz_q      <= (dvs_raw_q == '0);
          quo_q     <= dnd_neg ? -dnd_raw_q : dnd_raw_q;
          dvs_mag_q <= dvs_neg ? -dvs_raw_q : dvs_raw_q;
          rem_q     <= '0;
          cnt_q     <= CW'(WIDTH - 1);
          state_q   <= S_ITER;
        end
        S_ITER: begin
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0)
            state_q <= S_FIX;
        end
        S_FIX: begin
          // divide-by-zero returns the dividend as given, bypassing sign fix-up
          if (dz_q)
            dout_q <= {{WIDTH{1'b1}}, dnd_raw_q};
          else
            dout_q <= {(qneg_q ? -quo_q : quo_q), (rneg_q ? -rem_q : rem_q)};
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          dvs_got_q <= 1'b0;
          dnd_got_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
